// File: rtl/chip8_test_sequencer.sv
// rtl/chip8_test_sequencer.sv - ROM->RAM program loader, CPU reset sequencer and probe checkpoint checker.
// Optional CHIP8_SEQ_STOP_ON_FAIL_EN: stop at first mismatch and freeze the CPU in reset.
module chip8_test_sequencer #(
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] PROG_BASE    = 'h200,
  parameter int                PROG_LEN     = 64,
  parameter int                RESET_CYCLES = 4,
  parameter int                RUN_CYCLES   = 1024,
  parameter int                NUM_CHECKS   = 4,
  parameter int                PROBE_W      = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          start,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [ADDR_W-1:0]             ram_address,
  output logic [DATA_W-1:0]             ram_data,
  output logic                          ram_wren,
  output logic                          cpu_reset_n,
  input  logic [PROBE_W-1:0]            probe,
  output logic [$clog2(NUM_CHECKS):0]   chk_idx,
  input  logic [31:0]                   chk_cycle,
  input  logic [PROBE_W-1:0]            chk_value,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [7:0]                    fail_count
);

  localparam int CW = $clog2(NUM_CHECKS) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  state_t        state, state_next;
  logic [31:0]   cnt;
  logic          hit, miss;
  logic          load_last, hold_last, run_last;
  logic [CW-1:0] idx_next;
  logic [31:0]   fail_sum;
  logic [7:0]    fail_next;

  // ROM is synchronous, so its output already lines up with the registered write strobe
  assign ram_data = rom_data;

  assign load_last = (cnt == 32'(PROG_LEN));
  assign hold_last = ((cnt + 32'd1) >= 32'(RESET_CYCLES));
  assign run_last  = (cnt == 32'(RUN_CYCLES - 1));
  assign hit       = (state == S_RUN) && (int'(chk_idx) < NUM_CHECKS) && (cnt == chk_cycle);
  assign miss      = hit && (probe != chk_value);
  assign idx_next  = chk_idx + CW'(hit);

`ifdef CHIP8_SEQ_STOP_ON_FAIL_EN
  always_comb begin
    fail_sum  = 32'(fail_count) + 32'(miss);
    fail_next = (fail_sum > 32'd255) ? 8'hFF : fail_sum[7:0];
  end
`else
  logic [31:0] unreached;
  assign unreached = 32'(NUM_CHECKS) - 32'(idx_next);

  // Checkpoints the run never reached are charged on the way into DONE
  always_comb begin
    fail_sum = 32'(fail_count) + 32'(miss);
    if (state == S_RUN && run_last) fail_sum = fail_sum + unreached;
    fail_next = (fail_sum > 32'd255) ? 8'hFF : fail_sum[7:0];
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = (PROG_LEN > 0) ? S_LOAD : S_HOLD;
      S_LOAD:         if (load_last) state_next = S_HOLD;
      S_HOLD:         if (hold_last) state_next = S_RUN;
`ifdef CHIP8_SEQ_STOP_ON_FAIL_EN
      S_RUN:          if (run_last || miss) state_next = S_DONE;
`else
      S_RUN:          if (run_last) state_next = S_DONE;
`endif
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rom_addr    <= '0;
      ram_address <= '0;
      ram_wren    <= 1'b0;
      cpu_reset_n <= 1'b0;
      chk_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_count  <= '0;
    end else begin
      state    <= state_next;
      ram_wren <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt         <= '0;
            rom_addr    <= '0;
            chk_idx     <= '0;
            fail_count  <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            cpu_reset_n <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_last) begin
            cnt <= '0;
          end else begin
            cnt         <= cnt + 32'd1;
            ram_wren    <= 1'b1;
            ram_address <= PROG_BASE + ADDR_W'(cnt);
            if ((cnt + 32'd1) < 32'(PROG_LEN)) rom_addr <= ADDR_W'(cnt + 32'd1);
          end
        end
        S_HOLD: begin
          if (hold_last) begin
            cnt         <= '0;
            cpu_reset_n <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_RUN: begin
          cnt        <= cnt + 32'd1;
          chk_idx    <= idx_next;
          fail_count <= fail_next;
          if (state_next == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (fail_next == 8'd0);
`ifdef CHIP8_SEQ_STOP_ON_FAIL_EN
            if (miss) cpu_reset_n <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_test_sequencer.sv
// tb/tb_chip8_test_sequencer.sv - scoreboard bench for chip8_test_sequencer (main DUT plus PROG_LEN=0 DUT).
module tb_chip8_test_sequencer;

  localparam int PL  = 4;
  localparam int RC  = 4;
  localparam int RUN = 400;
  localparam int NC  = 300;
  localparam int LH  = PL + 1 + RC;
  localparam int LAT = LH + RUN;
`ifdef CHIP8_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [11:0] rom_addr, ram_address;
  logic [7:0]  rom_data, ram_data, probe, chk_value, fail_count;
  logic        ram_wren, cpu_reset_n, busy, done, pass;
  logic [9:0]  chk_idx;
  logic [31:0] chk_cycle;

  logic        start0, ram_wren0, crn0, busy0, done0, pass0;
  logic [11:0] rom_addr0, ram_address0;
  logic [7:0]  rom_data0, ram_data0, probe0, chk_value0, fail0;
  logic [0:0]  chk_idx0;
  logic [31:0] chk_cycle0;

  chip8_test_sequencer #(.PROG_LEN(PL), .RESET_CYCLES(RC), .RUN_CYCLES(RUN), .NUM_CHECKS(NC)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .cpu_reset_n(cpu_reset_n),
    .probe(probe), .chk_idx(chk_idx), .chk_cycle(chk_cycle), .chk_value(chk_value),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count));

  chip8_test_sequencer #(.PROG_LEN(0), .RESET_CYCLES(4), .RUN_CYCLES(20), .NUM_CHECKS(1)) dut0 (
    .CLOCK_50(clk), .reset(reset), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .ram_address(ram_address0), .ram_data(ram_data0), .ram_wren(ram_wren0), .cpu_reset_n(crn0),
    .probe(probe0), .chk_idx(chk_idx0), .chk_cycle(chk_cycle0), .chk_value(chk_value0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fail0));

  int         cyc = 0;
  int         t_base = 1 << 30;
  int         run_cyc;
  int         tcyc [NC];
  logic [7:0] tval [NC];
  logic [7:0] obs  [512];
  logic [7:0] rom_mem [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr[1:0]];

  assign run_cyc    = cyc - t_base;
  assign rom_data0  = 8'h00;
  assign probe0     = 8'h3C;
  assign chk_value0 = 8'h3C;
  assign chk_cycle0 = (chk_idx0 == 1'b0) ? 32'd5 : 32'hFFFF_FFFF;

  always_comb begin
    chk_cycle = 32'hFFFF_FFFF;
    chk_value = 8'h00;
    if (int'(chk_idx) < NC) begin
      chk_cycle = 32'(tcyc[chk_idx]);
      chk_value = tval[chk_idx];
    end
  end

  always_comb begin
    probe = 8'hEE;
    if (run_cyc >= 0 && run_cyc < 512) probe = obs[run_cyc];
  end

  typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;
  typedef struct { int fail; int lat; logic crn; } res_t;
  wr_t  wq[$];
  res_t rq[$];
  int   total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic set_base();
    for (int i = 0; i < 512; i++) obs[i] = 8'hEE;
    for (int i = 0; i < NC; i++) begin
      tcyc[i] = (i == 0) ? 2 : (i == 1) ? 10 : 9 + i;
      tval[i] = (i == 0) ? 8'h00 : (i == 1) ? 8'h58 : 8'(i & 127);
      obs[tcyc[i]] = tval[i];
    end
  endtask

  task automatic do_run(input string tag, input int ef, input int el, input logic ecrn, input bit poke);
    res_t r;
    wr_t  w;
    int   c, n, wcount;
    bit   got_done;
    r.fail = ef; r.lat = el; r.crn = ecrn;
    rq.push_back(r);
    for (int k = 0; k < PL; k++) begin
      w.a = 12'h200 + 12'(k);
      w.d = rom_mem[k];
      wq.push_back(w);
    end
    wcount = 0;
    got_done = 1'b0;
    n = 0;
    @(negedge clk);
    c = cyc;
    t_base = c + 1 + LH;
    start = 1'b1;
    while (n < 2000 && !got_done) begin
      @(negedge clk);
      n++;
      start = poke && (run_cyc == 100);
      if (poke && run_cyc == 101) check({tag, "_busy_poke"}, 32'(busy), 32'd1);
      if (n == 3) check({tag, "_busy_load"}, 32'(busy), 32'd1);
      if (ram_wren) begin
        wcount++;
        if (wq.size() == 0) check({tag, "_wr_extra"}, 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          check({tag, "_wr_addr"}, 32'(ram_address), 32'(w.a));
          check({tag, "_wr_data"}, 32'(ram_data), 32'(w.d));
        end
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    r = rq.pop_front();
    check({tag, "_latency"}, 32'(cyc - (c + 1)), 32'(r.lat));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(r.fail));
    check({tag, "_pass"}, 32'(pass), 32'(r.fail == 0));
    check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(r.crn));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_wr_count"}, 32'(wcount), 32'(PL));
    check({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start0 = 1'b0;
    set_base();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail_count), 32'd0);
    check("rst_idx", 32'(chk_idx), 32'd0);
    check("rst_crn", 32'(cpu_reset_n), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;

    set_base();
    do_run("match", 0, LAT, 1'b1, 1'b1);
    check("match_idx", 32'(chk_idx), 32'(NC));

    set_base();
    obs[10] = 8'h57;
    do_run("miss10", 1, STOP ? LH + 11 : LAT, STOP ? 1'b0 : 1'b1, 1'b0);

    set_base();
    tcyc[NC-1] = RUN;
    do_run("unreached", STOP ? 0 : 1, LAT, 1'b1, 1'b0);

    set_base();
    for (int i = 0; i < NC; i++) obs[tcyc[i]] = ~tval[i];
    do_run("allmiss", STOP ? 1 : 255, STOP ? LH + 3 : LAT, STOP ? 1'b0 : 1'b1, 1'b0);

    set_base();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_in_load", 32'(ram_wren), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wren", 32'(ram_wren), 32'd0);
    check("abort_crn", 32'(cpu_reset_n), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fail", 32'(fail_count), 32'd0);

    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("p0_busy", 32'(busy0), 32'd1);
    check("p0_crn_start", 32'(crn0), 32'd0);
    check("p0_wren_start", 32'(ram_wren0), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("p0_crn_%0d", i), 32'(crn0), 32'(i == 4));
      check($sformatf("p0_wren_%0d", i), 32'(ram_wren0), 32'd0);
    end
    for (int i = 0; i < 100 && !done0; i++) begin
      @(negedge clk);
      if (ram_wren0) check("p0_wren_run", 32'd1, 32'd0);
    end
    check("p0_done", 32'(done0), 32'd1);
    check("p0_pass", 32'(pass0), 32'd1);
    check("p0_fail", 32'(fail0), 32'd0);
    check("p0_crn_done", 32'(crn0), 32'd1);
    check("p0_idx", 32'(chk_idx0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
